// File: rtl/afifo_pkg.sv
// rtl/afifo_pkg.sv - shared constants and state encoding for the async-FIFO write framer
// Contents: FIFO data width, default header tag, framer FSM state encoding.

package afifo_pkg;

    localparam int         FIFO_DW     = 8;
    localparam logic [3:0] HDR_TAG_DEF = 4'hA;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD_ENC = 2'd1;
    localparam logic [1:0] ST_CSUM_ENC    = 2'd2;
    localparam logic [1:0] ST_DROP_ENC    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE_ENC,
        PAYLOAD = ST_PAYLOAD_ENC,
        CSUM    = ST_CSUM_ENC,
        DROP    = ST_DROP_ENC
    } state_t;

endpackage

// File: rtl/afifo_out_reg.sv
// rtl/afifo_out_reg.sv - one-entry output holding register driving the FIFO write port
// Ports: wclk, rstn (async, active-low); i_load/i_data/i_tag load request;
//        fifo_full from FIFO; o_free (may load this cycle), o_valid, o_data, o_tag,
//        o_wr_en (full-gated write strobe).

module afifo_out_reg
    import afifo_pkg::*;
(
    input  logic               wclk,
    input  logic               rstn,
    input  logic               i_load,
    input  logic [FIFO_DW-1:0] i_data,
    input  logic               i_tag,
    input  logic               fifo_full,
    output logic               o_free,
    output logic               o_valid,
    output logic [FIFO_DW-1:0] o_data,
    output logic               o_tag,
    output logic               o_wr_en
);

    logic               r_valid;
    logic [FIFO_DW-1:0] r_data;
    logic               r_tag;

    // The entry is free when empty or when its byte drains this cycle.
    assign o_free  = !r_valid || !fifo_full;
    assign o_wr_en = r_valid && !fifo_full;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_tag   = r_tag;

    always_ff @(posedge wclk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tag   <= 1'b0;
        end else if (i_load && o_free) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_tag   <= i_tag;
        end else if (o_wr_en) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/afifo_wr_framer.sv
// rtl/afifo_wr_framer.sv - frames a byte stream as header/payload/checksum into an async FIFO
// Ports: wclk, rstn (async, active-low); s_valid/s_ready/s_data/s_last upstream bytes;
//        fifo_full, fifo_wr_en, fifo_wdata FIFO write port; pkt_cnt completed frames;
//        busy; trunc_err (only with PKT_MAXLEN_EN).
// Build option: PKT_MAXLEN_EN caps payload at MAX_LEN bytes and drops the remainder.

module afifo_wr_framer
    import afifo_pkg::*;
#(
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEF
`ifdef PKT_MAXLEN_EN
    ,
    parameter int         MAX_LEN = 16
`endif
) (
    input  logic               wclk,
    input  logic               rstn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [FIFO_DW-1:0] s_data,
    input  logic               s_last,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [FIFO_DW-1:0] fifo_wdata,
    output logic [15:0]        pkt_cnt,
    output logic               busy
`ifdef PKT_MAXLEN_EN
    ,
    output logic               trunc_err
`endif
);

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_seq;
    logic [FIFO_DW-1:0] r_csum, w_csum_nxt;
    logic [15:0]        r_pkt_cnt;
    logic               w_load, w_tag, w_seq_inc;
    logic [FIFO_DW-1:0] w_ld_data, w_hdr;
    logic               w_ob_free, w_ob_valid, w_ob_tag;

`ifdef PKT_MAXLEN_EN
    localparam logic [7:0] LEN_LAST = 8'(MAX_LEN - 1);
    logic [7:0] r_len, w_len_nxt;
    logic       r_drop, w_drop_nxt;
    logic       r_trunc_err, w_trunc;
`endif

    assign w_hdr = {HDR_TAG, r_seq};

    afifo_out_reg u_out_reg (
        .wclk      (wclk),
        .rstn      (rstn),
        .i_load    (w_load),
        .i_data    (w_ld_data),
        .i_tag     (w_tag),
        .fifo_full (fifo_full),
        .o_free    (w_ob_free),
        .o_valid   (w_ob_valid),
        .o_data    (fifo_wdata),
        .o_tag     (w_ob_tag),
        .o_wr_en   (fifo_wr_en)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_csum_nxt  = r_csum;
        w_load      = 1'b0;
        w_ld_data   = w_hdr;
        w_tag       = 1'b0;
        w_seq_inc   = 1'b0;
        s_ready     = 1'b0;
`ifdef PKT_MAXLEN_EN
        w_len_nxt   = r_len;
        w_drop_nxt  = r_drop;
        w_trunc     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // Header goes out as soon as a packet shows up; its first
                // payload byte is taken on a later cycle.
                if (s_valid && w_ob_free) begin
                    w_load      = 1'b1;
                    w_ld_data   = w_hdr;
                    w_csum_nxt  = w_hdr;
                    w_state_nxt = PAYLOAD;
`ifdef PKT_MAXLEN_EN
                    w_len_nxt   = 8'd0;
`endif
                end
            end
            PAYLOAD: begin
                s_ready = w_ob_free;
                if (s_valid && w_ob_free) begin
                    w_load     = 1'b1;
                    w_ld_data  = s_data;
                    w_csum_nxt = r_csum ^ s_data;
`ifdef PKT_MAXLEN_EN
                    w_len_nxt  = r_len + 8'd1;
                    if (s_last) begin
                        w_state_nxt = CSUM;
                    end else if (r_len == LEN_LAST) begin
                        w_state_nxt = CSUM;
                        w_drop_nxt  = 1'b1;
                        w_trunc     = 1'b1;
                    end
`else
                    if (s_last) begin
                        w_state_nxt = CSUM;
                    end
`endif
                end
            end
            CSUM: begin
                if (w_ob_free) begin
                    w_load      = 1'b1;
                    w_ld_data   = r_csum;
                    w_tag       = 1'b1;
                    w_seq_inc   = 1'b1;
                    w_state_nxt = IDLE;
`ifdef PKT_MAXLEN_EN
                    if (r_drop) begin
                        w_state_nxt = DROP;
                    end
                    w_drop_nxt = 1'b0;
`endif
                end
            end
`ifdef PKT_MAXLEN_EN
            DROP: begin
                // Swallow the rest of a truncated packet without touching the FIFO.
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_csum    <= '0;
            r_seq     <= 4'd0;
            r_pkt_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_csum  <= w_csum_nxt;
            if (w_seq_inc) begin
                r_seq <= r_seq + 4'd1;
            end
            // A frame is complete when its tagged checksum byte is written.
            if (fifo_wr_en && w_ob_tag) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

`ifdef PKT_MAXLEN_EN
    always_ff @(posedge wclk or negedge rstn) begin
        if (!rstn) begin
            r_len       <= 8'd0;
            r_drop      <= 1'b0;
            r_trunc_err <= 1'b0;
        end else begin
            r_len       <= w_len_nxt;
            r_drop      <= w_drop_nxt;
            r_trunc_err <= w_trunc;
        end
    end

    assign trunc_err = r_trunc_err;
`endif

    assign pkt_cnt = r_pkt_cnt;
    assign busy    = (r_state != IDLE) || w_ob_valid;

endmodule

// File: tb/tb_afifo_wr_framer.sv
// tb/tb_afifo_wr_framer.sv - scoreboard bench for afifo_wr_framer (default and PKT_MAXLEN_EN builds)

module tb_afifo_wr_framer;

    logic       wclk = 1'b0;
    logic       rstn = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       fifo_full = 1'b0;
    logic       fifo_wr_en;
    logic [7:0] fifo_wdata;
    logic [15:0] pkt_cnt;
    logic       busy;

`ifdef PKT_MAXLEN_EN
    localparam int TB_MAX = 4;
    logic trunc_err;
    int   trunc_seen = 0;
    int   trunc_exp  = 0;
`endif

    always #5 wclk = ~wclk;

    afifo_wr_framer #(
        .HDR_TAG (4'hA)
`ifdef PKT_MAXLEN_EN
        ,
        .MAX_LEN (TB_MAX)
`endif
    ) dut (
        .wclk       (wclk),
        .rstn       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .pkt_cnt    (pkt_cnt),
        .busy       (busy)
`ifdef PKT_MAXLEN_EN
        ,
        .trunc_err  (trunc_err)
`endif
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         sb_en  = 1'b0;
    int         m_seq  = 0;
    int         m_pkts = 0;
    int         full_mode = 0;
    int         full_hold = 0;
    bit         hit22 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected byte.
    always @(negedge wclk) begin
        if (rstn && fifo_wr_en) begin
            chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write act=%02h req=none t=%0t", fifo_wdata, $time);
                end else begin
                    chk("wdata", {24'd0, fifo_wdata}, {24'd0, exp_q.pop_front()});
                end
            end
        end
`ifdef PKT_MAXLEN_EN
        if (rstn && trunc_err) trunc_seen++;
`endif
    end

    // Back-pressure generator.
    always @(posedge wclk) begin
        #1;
        if (full_hold > 0) begin
            fifo_full = 1'b1;
            full_hold--;
        end else if (full_mode == 2 && !hit22 && fifo_wdata == 8'h22) begin
            hit22     = 1'b1;
            fifo_full = 1'b1;
            full_hold = 3;
        end else if (full_mode == 1) begin
            fifo_full = ($urandom_range(0, 3) == 0);
        end else begin
            fifo_full = 1'b0;
        end
    end

    // Reference frame: header {A, seq}, payload (capped when truncating), XOR of all.
    task automatic model_pkt(input logic [7:0] pl[$]);
        logic [7:0] hdr, cs;
        int n;
        hdr = {4'hA, 4'(m_seq)};
        exp_q.push_back(hdr);
        cs = hdr;
        n = pl.size();
`ifdef PKT_MAXLEN_EN
        if (n > TB_MAX) begin
            n = TB_MAX;
            trunc_exp++;
        end
`endif
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pl[i]);
            cs = cs ^ pl[i];
        end
        exp_q.push_back(cs);
        m_seq  = (m_seq + 1) % 16;
        m_pkts = m_pkts + 1;
    endtask

    task automatic send_pkt(input logic [7:0] pl[$], input int gap_max, input bit chk_busy);
        bit hs;
        int budget;
        model_pkt(pl);
        for (int i = 0; i < pl.size(); i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap_max; g++) begin
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    @(negedge wclk);
                    if (chk_busy) chk("busy_in_gap", {31'd0, busy}, 32'd1);
                    @(posedge wclk);
                    #1;
                end
            end
            s_valid = 1'b1;
            s_data  = pl[i];
            s_last  = (i == pl.size() - 1);
            budget  = 0;
            hs      = 1'b0;
            while (!hs && budget < 200) begin
                @(negedge wclk);
                hs = s_ready;
                @(posedge wclk);
                #1;
                budget++;
            end
            if (!hs) begin
                n_chk++;
                n_fail++;
                $display("FAIL handshake_timeout act=no_accept req=accept byte=%0d", i);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain(input string nm);
        int budget;
        budget = 0;
        while (budget < 1000) begin
            @(negedge wclk);
            if (exp_q.size() == 0 && !busy) break;
            budget++;
        end
        chk({nm, "_remaining"}, exp_q.size(), 32'd0);
        chk({nm, "_pkt_cnt"}, {16'd0, pkt_cnt}, 32'(m_pkts % 65536));
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) begin
            @(negedge wclk);
            chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
            chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        end
        exp_q.delete();
        m_seq  = 0;
        m_pkts = 0;
        @(posedge wclk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        logic [7:0] q[$];
        int len, gap;

        do_reset();
        sb_en = 1'b1;

        // Basic 3-byte packet, no back-pressure.
        q = {8'h11, 8'h22, 8'h33};
        send_pkt(q, 0, 1'b0);
        drain("pkt3");

        // Same packet with full held for 4 cycles while 0x22 is pending.
        full_mode = 2;
        hit22 = 1'b0;
        send_pkt(q, 0, 1'b0);
        drain("pkt3_full");
        full_mode = 0;

        // Reset mid-stream, outputs must go quiet while rstn is low.
        sb_en   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h77;
        s_last  = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        do_reset();
        sb_en = 1'b1;

        // 17 back-to-back single-byte packets: header sequence wraps.
        q = {8'h05};
        for (int p = 0; p < 17; p++) send_pkt(q, 0, 1'b0);
        drain("single17");

        // Payload with 2-cycle s_valid gaps.
        q = {8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'hFF};
        send_pkt(q, 2, 1'b1);
        drain("gaps");

`ifdef PKT_MAXLEN_EN
        q = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
        send_pkt(q, 0, 1'b0);
        drain("trunc6");
        chk("trunc_pulses_6", trunc_seen, trunc_exp);
`endif

        // Randomized packets under random back-pressure.
        full_mode = 1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 20);
            gap = $urandom_range(0, 2);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
            send_pkt(q, gap, 1'b0);
        end
        full_mode = 0;
        drain("random");

`ifdef PKT_MAXLEN_EN
        chk("trunc_pulses_all", trunc_seen, trunc_exp);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
